reg_file: RTL and testbench

Architectural register file for the MIPS datapath: 32 x 32-bit general-purpose registers with two asynchronous read ports and one synchronous write port. Its write port takes the writeback word produced by the memory-to-register selection stage: ALU result, load data, or next-PC for link instructions. Its read ports feed the ALU operand path and the store-data path. Register $zero is hardwired; $sp has a configurable reset value.

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_if.sv | 43 ++++
 rtl/reg_file_read_port.sv | 47 ++++
 rtl/reg_file.sv | 72 +++++++
 tb/tb_reg_file.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Brief    : Shared constants for the MIPS architectural register file and
//             the writeback selection logic that feeds it.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int          DATA_W_DEF  = 32;
    localparam int          ADDR_W_DEF  = 5;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_03FC;

    // Architectural register indices; REG_RA is consumed by the link-writeback mux.
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_if
//  Brief    : Read/write port bundle between the datapath and reg_file.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;

    modport master (
        output readReg1,
        output readReg2,
        output writeReg,
        output writeData,
        output regWrite,
        input  readData1,
        input  readData2
    );

    modport slave (
        input  readReg1,
        input  readReg2,
        input  writeReg,
        input  writeData,
        input  regWrite,
        output readData1,
        output readData2
    );

endinterface : reg_file_if
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_read_port
//  Brief    : One combinational read port: index -> data with $zero forcing
//             and an optional write-through compare (REGFILE_BYPASS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic [DATA_W-1:0] regs_i [2**ADDR_W],
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    output logic      [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] w_stored;

    always_comb begin
        w_stored = regs_i[rd_addr_i];
        if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
            w_stored = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // wr_en_i already excludes $zero and reset, so a match never targets r0.
    always_comb begin
        rd_data_o = w_stored;
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end
    end
`else
    logic w_unused_bypass;

    assign w_unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign rd_data_o       = w_stored;
`endif

endmodule : reg_file_read_port
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Brief    : 2^ADDR_W x DATA_W MIPS register file, two async read ports, one
//             sync write port, $zero hardwired, $sp reset to SP_INIT.
//             Define REGFILE_BYPASS_EN for write-before-read on the read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int          DATA_W  = DATA_W_DEF,
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter logic [31:0] SP_INIT = SP_INIT_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    reg_file_if.slave bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              w_we;

    // Reset gates the enable so neither the array nor the bypass sees a write.
    assign w_we = bus.regWrite && !reset && (bus.writeReg != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (w_we) begin
            regs_d[bus.writeReg] = bus.writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == REG_SP) ? DATA_W'(SP_INIT) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .regs_i    (regs_q),
        .rd_addr_i (bus.readReg1),
        .wr_en_i   (w_we),
        .wr_addr_i (bus.writeReg),
        .wr_data_i (bus.writeData),
        .rd_data_o (bus.readData1)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .regs_i    (regs_q),
        .rd_addr_i (bus.readReg2),
        .wr_en_i   (w_we),
        .wr_addr_i (bus.writeReg),
        .wr_data_i (bus.writeData),
        .rd_data_o (bus.readData2)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Brief    : Directed self-checking bench for reg_file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int          DATA_W  = 32;
    localparam int          ADDR_W  = 5;
    localparam logic [31:0] SP_INIT = 32'h0000_03FC;

    logic clk;
    logic reset;
    int   r_checks;
    int   r_failures;

    reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        bus.regWrite  = 1'b1;
        bus.writeReg  = idx;
        bus.writeData = data;
        tick();
        bus.regWrite  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_checks      = 0;
        r_failures    = 0;
        reset         = 1'b1;
        bus.readReg1  = '0;
        bus.readReg2  = '0;
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd5;
        bus.writeData = 32'hFFFF_FFFF;

        // Reset held over edges while a write to r5 is attempted.
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.readReg1 = 5'(i);
            #1;
            check_eq($sformatf("reset_sweep_r%0d", i), bus.readData1,
                     (i == 29) ? SP_INIT : 32'h0);
        end
        bus.readReg2 = 5'd5;
        #1;
        check_eq("reset_write_ignored_p2", bus.readData2, 32'h0);

        bus.regWrite = 1'b0;
        reset        = 1'b0;
        tick();
        bus.readReg1 = 5'd5;
        #1;
        check_eq("post_reset_r5", bus.readData1, 32'h0);

        // Basic write/read on both ports.
        write_reg(5'd8, 32'hDEAD_BEEF);
        bus.readReg1 = 5'd8;
        bus.readReg2 = 5'd8;
        #1;
        check_eq("r8_port1", bus.readData1, 32'hDEAD_BEEF);
        check_eq("r8_port2", bus.readData2, 32'hDEAD_BEEF);

        // $zero discards writes.
        write_reg(5'd0, 32'h1234_5678);
        bus.readReg1 = 5'd0;
        #1;
        check_eq("r0_stays_zero", bus.readData1, 32'h0);

        // Enable gating.
        bus.regWrite  = 1'b0;
        bus.writeReg  = 5'd9;
        bus.writeData = 32'hFFFF_FFFF;
        tick();
        bus.readReg1 = 5'd9;
        #1;
        check_eq("r9_gated", bus.readData1, 32'h0);

        // Same-cycle read of the write target (link PC into r31).
        write_reg(5'd31, 32'h0000_0010);
        bus.readReg2  = 5'd31;
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd31;
        bus.writeData = 32'h0000_0040;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("r31_pre_edge_bypass", bus.readData2, 32'h0000_0040);
`else
        check_eq("r31_pre_edge_old", bus.readData2, 32'h0000_0010);
`endif
        tick();
        bus.regWrite = 1'b0;
        #1;
        check_eq("r31_post_edge", bus.readData2, 32'h0000_0040);

        // Independent ports on distinct registers.
        bus.readReg1 = 5'd8;
        bus.readReg2 = 5'd29;
        #1;
        check_eq("dual_r8", bus.readData1, 32'hDEAD_BEEF);
        check_eq("dual_r29", bus.readData2, SP_INIT);

        // Async reset between edges clears r3 immediately.
        write_reg(5'd3, 32'hA5A5_A5A5);
        bus.readReg1 = 5'd3;
        #1;
        check_eq("r3_written", bus.readData1, 32'hA5A5_A5A5);
        #1;
        reset = 1'b1;
        #1;
        check_eq("r3_async_clear", bus.readData1, 32'h0);
        check_eq("r29_async_restore", bus.readData2, SP_INIT);

        // Reset coinciding with a write-enabled edge: the write must not land.
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd6;
        bus.writeData = 32'h6666_6666;
        tick();
        bus.regWrite = 1'b0;
        reset        = 1'b0;
        bus.readReg1 = 5'd6;
        #1;
        check_eq("r6_reset_wins", bus.readData1, 32'h0);

        // First edge after reset release accepts a write.
        reset = 1'b1;
        #1;
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd4;
        bus.writeData = 32'h0000_0077;
        @(negedge clk);
        reset = 1'b0;
        tick();
        bus.regWrite = 1'b0;
        bus.readReg1 = 5'd4;
        bus.readReg2 = 5'd8;
        #1;
        check_eq("r4_first_edge_write", bus.readData1, 32'h0000_0077);
        check_eq("r8_cleared_by_reset", bus.readData2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
